my_logic_reduce: RTL and testbench

MY_LOGIC_REDUCE -- requirements
Module: my_logic_reduce

---
 rtl/my_logic_pkg.sv | 30 +++
 rtl/my_reduce_lane.sv | 52 +++++
 rtl/my_logic_reduce.sv | 118 +++++++++++
 tb/tb_my_logic_reduce.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/my_logic_pkg.sv
// Shared mode encodings, occupancy states and parameter limits for the
// bitwise lane-reduction block.
package my_logic_pkg;

  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 32;
  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 8;

  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_NAND = 3'd3,
    MODE_NOR  = 3'd4,
    MODE_XNOR = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Encodings 6 and 7 are reserved and produce an error result.
  function automatic logic mode_illegal(input logic [2:0] mode);
    return (mode > 3'd5);
  endfunction

endpackage

// File: rtl/my_reduce_lane.sv
// Combinational bitwise reduction across the masked operand lanes.
// Illegal modes give a zero result with err set.
module my_reduce_lane
  import my_logic_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic [2:0]              mode,
  input  logic [NUM_IN-1:0]       mask,
  input  logic [NUM_IN*WIDTH-1:0] data,
  output logic [WIDTH-1:0]        result,
  output logic                    err
);

  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] or_r;
  logic [WIDTH-1:0] xor_r;

  // Identity values make an empty mask fall out naturally.
  always_comb begin
    and_r = '1;
    or_r  = '0;
    xor_r = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (mask[i]) begin
        and_r = and_r & data[i*WIDTH +: WIDTH];
        or_r  = or_r  | data[i*WIDTH +: WIDTH];
        xor_r = xor_r ^ data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    result = '0;
    err    = 1'b0;
    if (mode_illegal(mode)) begin
      err = 1'b1;
    end else begin
      case (mode_e'(mode))
        MODE_AND:  result = and_r;
        MODE_OR:   result = or_r;
        MODE_XOR:  result = xor_r;
        MODE_NAND: result = ~and_r;
        MODE_NOR:  result = ~or_r;
        MODE_XNOR: result = ~xor_r;
        default:   result = '0;
      endcase
    end
  end

endmodule

// File: rtl/my_logic_reduce.sv
// Bitwise lane reduction with a valid/ready input, an output register and
// one skid register, giving a two-deep FIFO with registered in_ready.
module my_logic_reduce
  import my_logic_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_mode,
  input  logic [NUM_IN-1:0]       in_mask,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("my_logic_reduce: WIDTH out of range");
  end
  if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
    $error("my_logic_reduce: NUM_IN out of range");
  end

  logic [WIDTH-1:0] res;
  logic             res_err;

  my_reduce_lane #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN)
  ) u_reduce (
    .mode  (in_mode),
    .mask  (in_mask),
    .data  (in_data),
    .result(res),
    .err   (res_err)
  );

  occ_e             state_q,     state_d;
  logic             in_ready_q,  in_ready_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_err_q,   out_err_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q,  skid_err_d;

  logic accept;
  logic drain;

  assign accept = in_valid && in_ready_q;
  assign drain  = (state_q != OCC_EMPTY) && out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          state_d    = OCC_ONE;
          out_data_d = res;
          out_err_d  = res_err;
        end
      end
      OCC_ONE: begin
        if (accept && drain) begin
          out_data_d = res;
          out_err_d  = res_err;
        end else if (accept) begin
          state_d     = OCC_FULL;
          skid_data_d = res;
          skid_err_d  = res_err;
        end else if (drain) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        // in_ready is low here, so only a drain can move data.
        if (drain) begin
          state_d    = OCC_ONE;
          out_data_d = skid_data_q;
          out_err_d  = skid_err_q;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    in_ready_d = (state_d != OCC_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OCC_EMPTY;
      in_ready_q  <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != OCC_EMPTY);
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_my_logic_reduce.sv
// Bench for my_logic_reduce: directed and random operations checked against
// a per-bit counting reference model with a two-entry expected-result queue.
module tb_my_logic_reduce;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2:0]     in_mode = '0;
  logic [N-1:0]   in_mask = '0;
  logic [N*W-1:0] in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic           out_err;

  my_logic_reduce #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_mask  (in_mask),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [W:0] exp_q[$];
  logic       mdl_ready = 1'b0;
  logic       last_acc  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Each result bit is derived from how many enabled lanes hold a 1 there.
  function automatic logic [W:0] ref_op(input logic [2:0] mode, input logic [N-1:0] mask,
                                        input logic [N*W-1:0] data);
    logic [W-1:0] r;
    int n_en, ones;
    logic a, o, x;
    if (mode >= 3'd6) return {1'b1, {W{1'b0}}};
    n_en = 0;
    for (int i = 0; i < N; i++) if (mask[i]) n_en++;
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int i = 0; i < N; i++) if (mask[i] && data[i*W+b]) ones++;
      a = (ones == n_en);
      o = (ones > 0);
      x = (ones % 2) == 1;
      case (mode)
        3'd0: r[b] = a;
        3'd1: r[b] = o;
        3'd2: r[b] = x;
        3'd3: r[b] = !a;
        3'd4: r[b] = !o;
        default: r[b] = !x;
      endcase
    end
    return {1'b0, r};
  endfunction

  // Check outputs at the negedge, advance the model across one rising edge.
  task automatic cycle();
    logic ev, acc, drn;
    logic [W:0] head;
    ev = (exp_q.size() > 0);
    chk("in_ready", in_ready, mdl_ready);
    chk("out_valid", out_valid, ev);
    if (ev) begin
      head = exp_q[0];
      chk("out_data", out_data, head[W-1:0]);
      chk("out_err", out_err, head[W]);
    end
    acc = in_valid && mdl_ready;
    drn = ev && out_ready;
    if (drn) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(ref_op(in_mode, in_mask, in_data));
    last_acc = acc;
    @(posedge clk);
    mdl_ready = (exp_q.size() < 2);
    @(negedge clk);
  endtask

  task automatic set_op(input logic [2:0] m, input logic [N-1:0] k, input logic [N*W-1:0] d);
    in_valid = 1'b1;
    in_mode  = m;
    in_mask  = k;
    in_data  = d;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_mode  = 3'($urandom);
    in_mask  = N'($urandom);
    in_data  = $urandom;
  endtask

  initial begin
    int n_acc;
    logic done;

    // Reset
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_err", out_err, 1'b0);
    rst_n = 1'b1;
    mdl_ready = 1'b0;
    cycle();
    cycle();

    // AND of four lanes
    out_ready = 1'b1;
    set_op(3'd0, 4'b1111, 32'hFFF03CFF);
    cycle();
    idle();
    chk("and_4lane", out_data, 8'h30);
    chk("and_4lane_err", out_err, 1'b0);
    cycle();

    // NOR on empty mask, XOR on two lanes with disabled lanes holding noise
    set_op(3'd4, 4'b0000, $urandom);
    cycle();
    chk("nor_empty", out_data, 8'hFF);
    set_op(3'd2, 4'b0101, 32'hAAFF550F);
    cycle();
    chk("xor_2lane", out_data, 8'hF0);
    set_op(3'd0, 4'b0000, $urandom);
    cycle();
    chk("and_empty", out_data, 8'hFF);
    set_op(3'd1, 4'b0010, 32'h00005A00);
    cycle();
    chk("or_single", out_data, 8'h5A);
    set_op(3'd5, 4'b1000, 32'h3C000000);
    cycle();
    chk("xnor_single", out_data, 8'hC3);

    // Illegal mode then a normal op
    set_op(3'd7, 4'b1111, $urandom);
    cycle();
    chk("illegal_data", out_data, 8'h00);
    chk("illegal_err", out_err, 1'b1);
    set_op(3'd1, 4'b0011, 32'h00001204);
    cycle();
    chk("after_illegal", out_data, 8'h16);
    chk("after_illegal_err", out_err, 1'b0);
    idle();
    cycle();

    // Back-pressure: A and B fill storage, C waits
    out_ready = 1'b0;
    set_op(3'd1, 4'b0001, 32'h000000A1);
    cycle();
    set_op(3'd1, 4'b0001, 32'h000000B2);
    cycle();
    set_op(3'd1, 4'b0001, 32'h000000C3);
    cycle();
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_head", out_data, 8'hA1);
    cycle();
    out_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      cycle();
      if (last_acc) begin
        done = 1'b1;
        idle();
      end
    end
    chk("c_accepted", done, 1'b1);
    repeat (3) cycle();
    chk("bp_drained", exp_q.size(), 0);

    // Sixteen back-to-back operations at full rate
    n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      set_op(3'($urandom_range(0, 5)), N'($urandom), $urandom);
      cycle();
      if (last_acc) n_acc++;
      chk("stream_valid", out_valid, 1'b1);
    end
    idle();
    chk("stream_accepts", n_acc, 16);
    cycle();
    cycle();

    // Random traffic including illegal modes and idle-time input churn
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) set_op(3'($urandom), N'($urandom), $urandom);
      else idle();
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    // Reset while full
    out_ready = 1'b0;
    set_op(3'd2, 4'b1111, $urandom);
    cycle();
    cycle();
    idle();
    cycle();
    chk("pre_rst_full", exp_q.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("rst_full_valid", out_valid, 1'b0);
    chk("rst_full_ready", in_ready, 1'b0);
    chk("rst_full_data", out_data, '0);
    exp_q.delete();
    mdl_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
